// File: rtl/im_loader_arbiter.sv
// im_loader_arbiter: shares the IM block RAM port between CPU fetch and a UART program loader.
// Optional trailing XOR checksum byte enabled by defining IM_LOAD_CHECKSUM_EN.
module im_loader_arbiter #(
  parameter int ADDR_W  = 11,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic [31:0]       pc,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_we,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  output logic              cpu_hold,
  output logic              cpu_restart,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);
  typedef enum logic [2:0] {
    RUN, HDR0, HDR1, LOAD,
`ifdef IM_LOAD_CHECKSUM_EN
    CHK,
`endif
    DONE, ERR
  } state_t;
  localparam logic [16:0] MAX_N    = 17'(1 << ADDR_W);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);
  state_t            state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [1:0]        byte_q, byte_d;
  logic [ADDR_W:0]   word_q, word_d;
  logic [23:0]       buf_q, buf_d;
  logic [31:0]       din_q, din_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [31:0]       tmo_q, tmo_d;
  logic [15:0]       hdr_n;
  logic [16:0]       wnext;
  logic              last, counting;
`ifdef IM_LOAD_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif
  assign hdr_n    = {n_q[15:8], rx_data};
  assign wnext    = 17'(word_q) + 17'd1;
  assign last     = we_q && (wnext == {1'b0, n_q});
  assign counting = (state_q != RUN) && (state_q != DONE) && (state_q != ERR);
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    byte_d  = byte_q;
    word_d  = word_q;
    buf_d   = buf_q;
    din_d   = din_q;
    we_d    = 1'b0;
`ifdef IM_LOAD_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      RUN:  if (load_req) state_d = HDR0;
      HDR0: if (rx_valid) begin
        n_d[15:8] = rx_data;
        state_d   = HDR1;
      end
      HDR1: if (rx_valid) begin
        n_d     = hdr_n;
        state_d = (hdr_n == 16'd0) ? DONE : ({1'b0, hdr_n} > MAX_N) ? ERR : LOAD;
      end
      LOAD: begin
        if (we_q) word_d = word_q + 1'b1;
        // A byte arriving during the final write is the checksum (or a stray trailer), not payload
        if (rx_valid && !last) begin
          buf_d  = {buf_q[15:0], rx_data};
          byte_d = byte_q + 2'd1;
`ifdef IM_LOAD_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (byte_q == 2'd3) begin
            we_d  = 1'b1;
            din_d = {buf_q, rx_data};
          end
        end
`ifdef IM_LOAD_CHECKSUM_EN
        if (last) state_d = rx_valid ? ((rx_data == csum_q) ? DONE : ERR) : CHK;
`else
        if (last) state_d = DONE;
`endif
      end
`ifdef IM_LOAD_CHECKSUM_EN
      CHK:  if (rx_valid) state_d = (rx_data == csum_q) ? DONE : ERR;
`endif
      DONE: state_d = RUN;
      ERR:  if (load_req) state_d = HDR0;
      default: state_d = RUN;
    endcase
    if (counting && state_d == state_q && !rx_valid && tmo_q == TMO_LAST) state_d = ERR;
    tmo_d = (!counting || rx_valid || state_d != state_q) ? 32'd0 : tmo_q + 32'd1;
    if (state_d == HDR0 && state_q != HDR0) begin
      word_d = '0;
      byte_d = 2'd0;
`ifdef IM_LOAD_CHECKSUM_EN
      csum_d = 8'd0;
`endif
    end
    err_d = (state_d == ERR) || (err_q && state_d != HDR0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      n_q     <= 16'd0;
      byte_q  <= 2'd0;
      word_q  <= '0;
      buf_q   <= 24'd0;
      din_q   <= 32'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 32'd0;
`ifdef IM_LOAD_CHECKSUM_EN
      csum_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      buf_q   <= buf_d;
      din_q   <= din_d;
      we_q    <= we_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
`ifdef IM_LOAD_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end
  assign ram_addr     = (state_q == RUN) ? pc[ADDR_W+1:2] : word_q[ADDR_W-1:0];
  assign ram_we       = (state_q == LOAD && we_q) ? 4'hF : 4'h0;
  assign ram_din      = din_q;
  assign instr        = (state_q == RUN && pc[1:0] == 2'b00 && pc[31:ADDR_W+2] == '0) ? ram_dout : 32'd0;
  assign cpu_hold     = (state_q != RUN);
  assign cpu_restart  = (state_q == DONE);
  assign load_err     = err_q;
  assign words_loaded = word_q;
endmodule

// File: doc/im_loader_arbiter.md
# im_loader_arbiter

Owns the single port of the instruction-memory block RAM and shares it between CPU instruction fetch and a UART-driven program loader. In RUN it forwards the CPU fetch address and gates the read data. On a load request it holds the CPU, assembles received bytes into 32-bit words, writes them sequentially from word 0, then pulses a CPU restart. It sits between the UART receiver, the CPU fetch stage and the IM block RAM on the P8 board design.

## Interface
- ADDR_W, 11, IM word-address width (2048 words = 8 KiB, byte range 0x0000–0x1FFF)
- TIMEOUT, 1000000, idle cycles allowed between received bytes during a load before abort
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- load_req  in  1  one-cycle pulse that starts a load
- rx_valid  in  1  one-cycle strobe; rx_data is valid
- rx_data  in  8  received byte
- pc  in  32  CPU fetch byte address
- instr  out  32  gated instruction to CPU
- ram_addr  out  ADDR_W  block RAM word address
- ram_we  out  4  block RAM byte write enables
- ram_din  out  32  block RAM write data
- ram_dout  in  32  block RAM read data
- cpu_hold  out  1  CPU must freeze fetch/commit while high
- cpu_restart  out  1  one-cycle pulse; CPU resets its PC to 0
- load_err  out  1  sticky error flag for the last load
- words_loaded  out  ADDR_W+1  words written by the current/last load

## Operation
- States: RUN, HDR0, HDR1, LOAD, CHK (only with the macro), DONE, ERR.
- RUN: ram_addr = pc[ADDR_W+1:2], ram_we = 0. instr = ram_dout when pc[1:0]==0 and pc<=0x1FFF, otherwise 0. rx bytes are ignored. cpu_hold = 0.
- In all states other than RUN: cpu_hold = 1 and instr = 0.
- load_req in RUN or ERR -> HDR0. load_req is ignored in the other states. Entry into HDR0 clears load_err and words_loaded.
- HDR0/HDR1: receive the 16-bit word count N as two bytes, big-endian (HDR0 takes the MSB).
  - N==0 -> DONE.
  - N>2048 -> ERR.
  - Otherwise -> LOAD.
- LOAD: bytes are packed big-endian. The first byte goes to bits [31:24].
  - On the 4th byte, the next cycle drives ram_we=4'b1111, ram_din=word and ram_addr=word index for exactly one cycle. words_loaded then increments.
  - ram_addr holds the write index throughout LOAD.
  - After write N-1 -> DONE.
- DONE: one cycle. cpu_restart=1, then -> RUN.
- ERR: cpu_hold stays 1 and load_err=1 until the next load_req.
- Timeout: a counter clears on every rx_valid and on state entry. It counts in HDR0, HDR1, LOAD and CHK. Reaching TIMEOUT-1 -> ERR. Words already written stay in RAM.
- Width rules: the byte index is a 2-bit counter and the word index is an ADDR_W+1 bit counter. Both reset to 0 on HDR0 entry.

## Timing
- Reset (async, rst_n low): state=RUN, cpu_hold=0, cpu_restart=0, ram_we=0, ram_din=0, load_err=0, words_loaded=0, all counters 0. RAM contents are untouched.
- Reset asserted mid-load: returns to RUN immediately. A partial image remains in RAM. No restart pulse is generated.
- The fetch path is combinational: pc to ram_addr, and ram_dout to instr. RAM read latency is the RAM's own, clocked outside this block.
- A RAM write occurs 1 cycle after the 4th byte's rx_valid.
- cpu_restart fires 2 cycles after the final byte's rx_valid (write cycle, then DONE). cpu_hold falls in the same cycle as the RUN entry.
- load_req and rx_valid in the same cycle in RUN: the byte is dropped and the state goes to HDR0.
- rx_valid in the cycle of a LOAD write is accepted. Back-to-back bytes every cycle are supported.

## Configuration
- IM_LOAD_CHECKSUM_EN defined:
  - An 8-bit XOR of all payload bytes (header excluded) is accumulated.
  - After the last write, the state goes to CHK and receives one checksum byte.
  - Match -> DONE. Mismatch -> ERR with load_err=1. The written words remain.
  - CHK is subject to the timeout.
- Undefined: there is no CHK state. After the last write the state goes to DONE, and a trailing byte would be ignored in RUN.

## Test plan
- Reset, then pc=0x0004 with ram_dout=0x2408000A -> instr=0x2408000A and cpu_hold=0. Then pc=0x0006 -> instr=0. Then pc=0x2000 -> instr=0.
- load_req, bytes 00 02 | 24 08 00 0A | 00 00 00 0C -> writes (addr 0, 0x2408000A) then (addr 1, 0x0000000C), each with ram_we=1111 for 1 cycle. words_loaded=2, then a single cpu_restart pulse and RUN.
- load_req, header 08 01 (N=2049) -> ERR, load_err=1, cpu_hold=1, no writes. A second load_req clears load_err.
- load_req, header 00 03, 5 payload bytes, then silence for TIMEOUT cycles -> ERR, words_loaded=1, no cpu_restart.
- rst_n pulsed low after 2 payload words -> RUN at once, cpu_hold=0, ram_we=0.
- With IM_LOAD_CHECKSUM_EN: header 00 01, payload 12 34 56 78, checksum 0x08 -> DONE. Repeat with checksum 0x09 -> ERR.
